// File: rtl/zigzag_encoder.sv
// zigzag_encoder: captures 8x8 blocks of signed 12-bit coefficients (eight
// 96-bit raster rows) into a ping-pong pair of banks and scans the full bank
// in JPEG zigzag order, emitting (value, run-of-zeros) tokens.
//
// Ports:
//   clk_in     clock, rising edge
//   rst_n_in   asynchronous active-low reset
//   column_in  one raster row, lane k = raster index 8*beat + k
//   valid_in   column_in valid
//   ready_out  write bank has room (registered)
//   value_out  token coefficient (two's complement)
//   run_out    zeros skipped in scan order before value_out
//   valid_out  token presented
//   ready_in   downstream accepts token
module zigzag_encoder (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [95:0] column_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic [11:0] value_out,
    output logic [5:0]  run_out,
    output logic        valid_out,
    input  logic        ready_in
);

    localparam int unsigned CW    = 12;
    localparam int unsigned LANES = 8;
    localparam int unsigned NPOS  = 64;
    localparam int unsigned PW    = 6;
    localparam int unsigned BW    = 3;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    // Zigzag position -> raster index
    localparam logic [PW-1:0] ZZ_LUT [NPOS] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [CW-1:0] mem_q [2][NPOS];

    logic [0:0]    state_q,  state_d;
    logic [PW-1:0] p_q,      p_d;
    logic [PW-1:0] z_q,      z_d;
    logic [1:0]    full_q,   full_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [BW-1:0] beat_q,   beat_d;
    logic          ready_q,  ready_d;
    logic [CW-1:0] value_q,  value_d;
    logic [PW-1:0] run_q,    run_d;
    logic          valid_q,  valid_d;

    logic          accept_c;
    logic          step_c;
    logic          last_pos_c;
    logic [CW-1:0] coef_c;

    assign accept_c   = valid_in && ready_q;
    // A full scan bank means scanning is (or may start) this cycle; p_q is 0 in IDLE
    assign step_c     = ((state_q == S_SCAN) || full_q[rd_ptr_q]) && (!valid_q || ready_in);
    assign last_pos_c = (p_q == PW'(NPOS - 1));
    assign coef_c     = mem_q[rd_ptr_q][ZZ_LUT[p_q]];

    // Coefficient banks: a whole row is written per accepted beat
    always_ff @(posedge clk_in) begin
        if (accept_c) begin
            for (int k = 0; k < int'(LANES); k++) begin
                mem_q[wr_ptr_q][{beat_q, BW'(k)}] <= column_in[CW*k +: CW];
            end
        end
    end

    // Next-state: capture bookkeeping, scan FSM and token outputs
    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        z_d      = z_q;
        full_d   = full_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        beat_d   = beat_q;
        value_d  = value_q;
        run_d    = run_q;
        valid_d  = valid_q;

        if (accept_c) begin
            beat_d = beat_q + BW'(1);
            if (beat_q == BW'(LANES - 1)) begin
                full_d[wr_ptr_q] = 1'b1;
                wr_ptr_d         = !wr_ptr_q;
            end
        end

        if (valid_q && ready_in) begin
            valid_d = 1'b0;
        end

        if (step_c) begin
            if ((coef_c != '0) || last_pos_c) begin
                value_d = coef_c;
                run_d   = z_q;
                valid_d = 1'b1;
                z_d     = '0;
            end else begin
                z_d = z_q + PW'(1);
            end

            if (last_pos_c) begin
                full_d[rd_ptr_q] = 1'b0;
                rd_ptr_d         = !rd_ptr_q;
                p_d              = '0;
                z_d              = '0;
                // Other bank already full: continue straight into it
                state_d          = full_q[!rd_ptr_q] ? S_SCAN : S_IDLE;
            end else begin
                p_d     = p_q + PW'(1);
                state_d = S_SCAN;
            end
        end

        ready_d = !full_d[wr_ptr_d];
    end

    // State registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= S_IDLE;
            p_q      <= '0;
            z_q      <= '0;
            full_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            beat_q   <= '0;
            ready_q  <= 1'b1;
            value_q  <= '0;
            run_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            z_q      <= z_d;
            full_q   <= full_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            beat_q   <= beat_d;
            ready_q  <= ready_d;
            value_q  <= value_d;
            run_q    <= run_d;
            valid_q  <= valid_d;
        end
    end

    assign ready_out = ready_q;
    assign value_out = value_q;
    assign run_out   = run_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_zigzag_encoder.sv
// tb_zigzag_encoder: directed table-driven bench for zigzag_encoder, plus
// sequences for all-nonzero timing, back-to-back blocks under backpressure
// with a decode-model loopback, and reset mid-capture / mid-scan.
module tb_zigzag_encoder;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [95:0] column_in;
    logic        valid_in;
    logic        ready_out;
    logic [11:0] value_out;
    logic [5:0]  run_out;
    logic        valid_out;
    logic        ready_in;

    zigzag_encoder dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .column_in(column_in),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .value_out(value_out),
        .run_out  (run_out),
        .valid_out(valid_out),
        .ready_in (ready_in)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int zz [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    typedef struct {
        int v;
        int r;
        int c;
    } tok_t;
    tok_t toks[$];

    // Token collector, stall-stability checker, ready_out watcher
    logic        prev_stall = 1'b0;
    logic [11:0] pv;
    logic [5:0]  pr;
    logic        saw_not_ready = 1'b0;
    logic        toggle_en = 1'b0;

    always @(negedge clk_in) begin
        if (rst_n_in) begin
            if (prev_stall) begin
                check("stall_valid_hold", int'(valid_out), 1);
                check("stall_value_hold", int'(value_out), int'(pv));
                check("stall_run_hold", int'(run_out), int'(pr));
            end
            if (valid_out && ready_in) begin
                tok_t t;
                t.v = int'($signed(value_out));
                t.r = int'(run_out);
                t.c = cyc;
                toks.push_back(t);
            end
            if (!ready_out) saw_not_ready = 1'b1;
            prev_stall = valid_out && !ready_in;
            pv = value_out;
            pr = run_out;
        end else begin
            prev_stall = 1'b0;
        end
    end

    always @(posedge clk_in) begin
        if (toggle_en) begin
            #1 ready_in = ~ready_in;
        end
    end

    typedef struct {
        int               nz_n;
        logic [2:0][5:0]  nz_idx;
        logic [2:0][11:0] nz_val;
        int               tok_n;
        logic [2:0][11:0] tv;
        logic [2:0][5:0]  tr;
        logic [2:0][5:0]  tp;
    } vec_t;
    vec_t vecs [5];

    task automatic send_beats(input int coef[64], input int nbeats, output int t_acc);
        int w;
        t_acc = -1;
        for (int r = 0; r < nbeats; r++) begin
            for (int k = 0; k < 8; k++) column_in[12*k +: 12] = 12'(coef[8*r+k]);
            valid_in = 1'b1;
            w = 0;
            @(negedge clk_in);
            while (!ready_out && w < 2000) begin
                @(negedge clk_in);
                w++;
            end
            if (!ready_out) check("beat_accept_timeout", 0, 1);
            t_acc = cyc;
            @(posedge clk_in);
            #1;
        end
        valid_in = 1'b0;
    endtask

    task automatic wait_tokens(input int n, input int budget);
        int w;
        w = 0;
        while (toks.size() < n && w < budget) begin
            @(posedge clk_in);
            w++;
        end
        #1;
        if (toks.size() < n) check("token_wait_timeout", toks.size(), n);
    endtask

    task automatic build_vec(input int v, output int coef[64]);
        for (int i = 0; i < 64; i++) coef[i] = 0;
        for (int j = 0; j < vecs[v].nz_n; j++)
            coef[int'(vecs[v].nz_idx[j])] = int'($signed(vecs[v].nz_val[j]));
    endtask

    task automatic run_vec(input int v, input string tag);
        int coef [64];
        int t;
        toks.delete();
        build_vec(v, coef);
        send_beats(coef, 8, t);
        wait_tokens(vecs[v].tok_n, 300);
        repeat (3) @(posedge clk_in);
        #1;
        check($sformatf("%s_v%0d_count", tag, v), toks.size(), vecs[v].tok_n);
        for (int j = 0; j < vecs[v].tok_n && j < toks.size(); j++) begin
            check($sformatf("%s_v%0d_t%0d_val", tag, v, j), toks[j].v, int'($signed(vecs[v].tv[j])));
            check($sformatf("%s_v%0d_t%0d_run", tag, v, j), toks[j].r, int'(vecs[v].tr[j]));
            check($sformatf("%s_v%0d_t%0d_cyc", tag, v, j), toks[j].c, t + 2 + int'(vecs[v].tp[j]));
        end
        check($sformatf("%s_v%0d_idle_valid", tag, v), int'(valid_out), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int coef_a [64];
    int blk [3][64];
    int rec [64];
    int t_acc;
    int exp_tok;
    int pos, b, mism;

    initial begin
        rst_n_in  = 1'b0;
        valid_in  = 1'b0;
        ready_in  = 1'b1;
        column_in = '0;

        // DC=5, raster63=-1
        vecs[0].nz_n = 2; vecs[0].nz_idx[0] = 6'd0; vecs[0].nz_val[0] = 12'd5;
        vecs[0].nz_idx[1] = 6'd63; vecs[0].nz_val[1] = 12'hFFF;
        vecs[0].tok_n = 2;
        vecs[0].tv[0] = 12'd5;   vecs[0].tr[0] = 6'd0;  vecs[0].tp[0] = 6'd0;
        vecs[0].tv[1] = 12'hFFF; vecs[0].tr[1] = 6'd62; vecs[0].tp[1] = 6'd63;
        // raster8=3 (zigzag position 2)
        vecs[1].nz_n = 1; vecs[1].nz_idx[0] = 6'd8; vecs[1].nz_val[0] = 12'd3;
        vecs[1].tok_n = 2;
        vecs[1].tv[0] = 12'd3; vecs[1].tr[0] = 6'd2;  vecs[1].tp[0] = 6'd2;
        vecs[1].tv[1] = 12'd0; vecs[1].tr[1] = 6'd60; vecs[1].tp[1] = 6'd63;
        // all zero
        vecs[2].nz_n = 0;
        vecs[2].tok_n = 1;
        vecs[2].tv[0] = 12'd0; vecs[2].tr[0] = 6'd63; vecs[2].tp[0] = 6'd63;
        // raster1=7 (pos1), raster2=-2 (pos5)
        vecs[3].nz_n = 2; vecs[3].nz_idx[0] = 6'd1; vecs[3].nz_val[0] = 12'd7;
        vecs[3].nz_idx[1] = 6'd2; vecs[3].nz_val[1] = 12'hFFE;
        vecs[3].tok_n = 3;
        vecs[3].tv[0] = 12'd7;   vecs[3].tr[0] = 6'd1;  vecs[3].tp[0] = 6'd1;
        vecs[3].tv[1] = 12'hFFE; vecs[3].tr[1] = 6'd3;  vecs[3].tp[1] = 6'd5;
        vecs[3].tv[2] = 12'd0;   vecs[3].tr[2] = 6'd57; vecs[3].tp[2] = 6'd63;
        // extreme values: DC=-2048, raster63=2047
        vecs[4].nz_n = 2; vecs[4].nz_idx[0] = 6'd0; vecs[4].nz_val[0] = 12'h800;
        vecs[4].nz_idx[1] = 6'd63; vecs[4].nz_val[1] = 12'h7FF;
        vecs[4].tok_n = 2;
        vecs[4].tv[0] = 12'h800; vecs[4].tr[0] = 6'd0;  vecs[4].tp[0] = 6'd0;
        vecs[4].tv[1] = 12'h7FF; vecs[4].tr[1] = 6'd62; vecs[4].tp[1] = 6'd63;

        repeat (3) @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        @(negedge clk_in);
        check("reset_ready_out", int'(ready_out), 1);
        check("reset_valid_out", int'(valid_out), 0);
        check("reset_value_out", int'(value_out), 0);
        check("reset_run_out", int'(run_out), 0);
        @(posedge clk_in);
        #1;

        for (int v = 0; v < 5; v++) run_vec(v, "tbl");

        // All coefficients nonzero: raster i = i+1, one token per cycle
        toks.delete();
        for (int i = 0; i < 64; i++) coef_a[i] = i + 1;
        send_beats(coef_a, 8, t_acc);
        wait_tokens(64, 300);
        repeat (3) @(posedge clk_in);
        #1;
        check("dense_count", toks.size(), 64);
        for (int p = 0; p < 64 && p < toks.size(); p++) begin
            check($sformatf("dense_p%0d_val", p), toks[p].v, zz[p] + 1);
            check($sformatf("dense_p%0d_run", p), toks[p].r, 0);
            check($sformatf("dense_p%0d_cyc", p), toks[p].c, t_acc + 2 + p);
        end

        // Three blocks back-to-back with ready_in toggling every cycle
        toks.delete();
        saw_not_ready = 1'b0;
        exp_tok = 0;
        for (int bb = 0; bb < 3; bb++) begin
            exp_tok++;
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    blk[bb][i] = int'($urandom_range(0, 4094)) - 2047;
                    if (blk[bb][i] == 0) blk[bb][i] = 1;
                end else begin
                    blk[bb][i] = 0;
                end
                if (i != 63 && blk[bb][i] != 0) exp_tok++;
            end
        end
        toggle_en = 1'b1;
        for (int bb = 0; bb < 3; bb++) begin
            for (int i = 0; i < 64; i++) coef_a[i] = blk[bb][i];
            send_beats(coef_a, 8, t_acc);
        end
        wait_tokens(exp_tok, 1500);
        repeat (4) @(posedge clk_in);
        toggle_en = 1'b0;
        @(posedge clk_in);
        #3 ready_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("b2b_token_count", toks.size(), exp_tok);
        check("b2b_ready_dropped", int'(saw_not_ready), 1);
        pos = 0;
        b = 0;
        for (int i = 0; i < 64; i++) rec[i] = 0;
        for (int j = 0; j < toks.size(); j++) begin
            pos += toks[j].r;
            if (pos < 64) rec[zz[pos]] = toks[j].v;
            pos++;
            if (pos >= 64) begin
                mism = 0;
                if (b < 3) begin
                    for (int i = 0; i < 64; i++) if (rec[i] != blk[b][i]) mism++;
                end
                check($sformatf("b2b_loopback_blk%0d_mismatches", b), mism, 0);
                b++;
                pos = 0;
                for (int i = 0; i < 64; i++) rec[i] = 0;
            end
        end
        check("b2b_blocks_decoded", b, 3);

        // Reset mid-scan of one block and mid-capture of the next
        toks.delete();
        for (int i = 0; i < 64; i++) coef_a[i] = i + 1;
        send_beats(coef_a, 8, t_acc);
        send_beats(coef_a, 4, t_acc);
        check("pre_reset_valid", int'(valid_out), 1);
        rst_n_in = 1'b0;
        #2;
        check("midrst_valid_out", int'(valid_out), 0);
        check("midrst_value_out", int'(value_out), 0);
        check("midrst_run_out", int'(run_out), 0);
        check("midrst_ready_out", int'(ready_out), 1);
        toks.delete();
        repeat (2) @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        repeat (10) @(posedge clk_in);
        #1;
        check("post_reset_no_tokens", toks.size(), 0);
        check("post_reset_valid", int'(valid_out), 0);
        run_vec(3, "rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
